mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles spent in WAIT before a bus error is declared.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream slot holds a real instruction.
- alu_result_in  in  32  effective address / ALU result.
- store_data_in  in  32  store operand.
- r_target_in  in  5  destination register.
- Reg_Write_in  in  1  writes register file.
- M2R_in  in  1  write-back selects memory data.
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- size_in  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- load_unsigned_in  in  1  zero-extend loads.
- stall  out  1  upstream holds all inputs stable while high.
- dm_req, dm_we  out  1 each  data-memory request / write strobe.
- dm_addr  out  32  word address {alu_result_in[31:2],2'b00}.
- dm_wdata  out  32  lane-replicated store data.
- dm_be  out  4  byte enables.
- dm_ack  in  1  memory completes request this cycle.
- dm_rdata  in  32  read data, valid with dm_ack.
- valid_out, address_out[31:0], data_out[31:0], r_target_out[4:0], Reg_Write_out, M2R_out  out  registered MEM/WB-facing fields.
- misalign_err, bus_err  out  1 each  one-cycle registered error pulses.

Function
REQ-003 SHALL implement FSM states IDLE and WAIT; a memory op is valid_in & (mem_read_in|mem_write_in).
REQ-004 SHALL treat an op as misaligned when size=01 and address[0]=1, or size=10/11 and address[1:0]!=0; misaligned ops issue no request.
REQ-005 SHALL, in IDLE with no memory op, register all inputs to outputs at the next edge (1-cycle latency), data_out=0, stall=0.
REQ-006 SHALL, in IDLE with an aligned memory op, drive dm_req=1 combinationally; dm_ack same cycle completes in 1 cycle, else move to WAIT.
REQ-007 SHALL hold dm_req=1 and stable dm_addr/dm_we/dm_be/dm_wdata throughout WAIT until dm_ack, then return to IDLE.
REQ-008 SHALL drive stall=1 whenever a memory request is outstanding and dm_ack=0 in that cycle; stall=0 in the ack cycle.
REQ-009 SHALL hold all registered outputs and force valid_out=0 at every edge while stall=1 (bubble to downstream).
REQ-010 SHALL, on the edge ending the ack cycle, register valid_out=1, address_out=alu_result_in, r_target_out, Reg_Write_out, M2R_out, and for loads data_out=extracted dm_rdata (stores: 0).
REQ-011 SHALL extract loads little-endian: byte lane address[1:0], half lane address[1], sign-extended unless load_unsigned_in.
REQ-012 SHALL generate dm_be: byte 0001<<address[1:0]; half 0011 or 1100 by address[1]; word 1111; dm_wdata byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd; dm_be=0 when dm_req=0.
REQ-013 SHALL, for a misaligned op, output valid_out=1 with Reg_Write_out=0 after one cycle and pulse misalign_err for that cycle.
REQ-014 SHALL count WAIT cycles; reaching TIMEOUT without dm_ack drops dm_req, returns to IDLE, deasserts stall, outputs valid_out=1 with Reg_Write_out=0, pulses bus_err.
REQ-015 SHALL prioritise dm_ack over timeout when both occur in the same cycle.
REQ-016 SHALL ignore dm_ack while no request is outstanding.

Reset
REQ-017 SHALL, on rst low, immediately clear all registered outputs to 0, state to IDLE, timeout counter to 0; dm_req, stall 0 while rst low.
REQ-018 SHALL abandon any WAIT transaction on reset; a later dm_ack is ignored.

Verification
REQ-019 ALU op, alu_result=0x1234, r_target=5, Reg_Write=1 -> next cycle valid_out=1, address_out=0x1234, data_out=0, stall never high.
REQ-020 lb, address 0x103, dm_rdata=0x80FF_FF00, ack after 3 cycles -> stall high 3 cycles, dm_be=1000, data_out=0xFFFF_FF80; with load_unsigned 0x0000_0080.
REQ-021 sh, address 0x202, store_data=0xABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCD_ABCD; on ack valid_out=1, data_out=0.
REQ-022 lw at 0x102 -> no dm_req, misalign_err pulse, valid_out=1, Reg_Write_out=0.
REQ-023 lw, dm_ack never -> stall high 15 cycles, bus_err pulse, Reg_Write_out=0; ack and timeout together -> normal completion.
REQ-024 rst low during WAIT -> dm_req, stall, outputs 0 immediately; late dm_ack after release produces no output.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests for loads/stores, stalls upstream
// while waiting, extracts/aligns load data and registers MEM/WB-facing fields.
module mem_stage #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  r_target_in,
   input  logic        Reg_Write_in,
   input  logic        M2R_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  size_in,
   input  logic        load_unsigned_in,
   output logic        stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        valid_out,
   output logic [31:0] address_out,
   output logic [31:0] data_out,
   output logic [4:0]  r_target_out,
   output logic        Reg_Write_out,
   output logic        M2R_out,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          valid_q, rw_q, m2r_q, mis_q, berr_q;
   logic [31:0]   addr_q, data_q;
   logic [4:0]    rt_q;

   logic        mem_op, misalign, req_raw, stall_raw, timeout_hit, done;
   logic [31:0] shifted, load_val;

   always_comb begin
      mem_op = valid_in & (mem_read_in | mem_write_in);
      case (size_in)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = alu_result_in[0];
         default: misalign = |alu_result_in[1:0];
      endcase
      req_raw     = mem_op & ~misalign;
      // The last WAIT cycle keeps the request up so a late ack still wins over the timeout.
      timeout_hit = (state_q == S_WAIT) && (cnt_q == CNT_LAST);
      stall_raw   = req_raw & ~dm_ack & ~timeout_hit;
      done        = req_raw & (dm_ack | timeout_hit);
   end

   assign dm_req   = req_raw & rst;
   assign stall    = stall_raw & rst;
   assign dm_we    = dm_req & mem_write_in;
   assign dm_addr  = {alu_result_in[31:2], 2'b00};

   always_comb begin
      dm_be    = 4'b0000;
      dm_wdata = store_data_in;
      case (size_in)
         2'b00: begin
            dm_be    = 4'b0001 << alu_result_in[1:0];
            dm_wdata = {4{store_data_in[7:0]}};
         end
         2'b01: begin
            dm_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
            dm_wdata = {2{store_data_in[15:0]}};
         end
         default: dm_be = 4'b1111;
      endcase
      if (!dm_req) dm_be = 4'b0000;
   end

   always_comb begin
      shifted = dm_rdata >> {alu_result_in[1:0], 3'b000};
      case (size_in)
         2'b00:   load_val = load_unsigned_in ? {24'b0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = load_unsigned_in ? {16'b0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
         default: load_val = dm_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rt_q    <= '0;
         rw_q    <= 1'b0;
         m2r_q   <= 1'b0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         mis_q  <= 1'b0;
         berr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (stall_raw) state_q <= S_WAIT;
            end
            default: begin
               if (stall_raw) begin
                  cnt_q <= cnt_q + CW'(1);
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            end
         endcase

         if (stall_raw) begin
            valid_q <= 1'b0;
         end else if (done) begin
            valid_q <= 1'b1;
            addr_q  <= alu_result_in;
            rt_q    <= r_target_in;
            m2r_q   <= M2R_in;
            if (dm_ack) begin
               rw_q   <= Reg_Write_in;
               data_q <= (mem_read_in & ~mem_write_in) ? load_val : 32'b0;
            end else begin
               rw_q   <= 1'b0;
               data_q <= '0;
               berr_q <= 1'b1;
            end
         end else if (mem_op) begin
            // Only a misaligned op reaches here: retire it as a non-writing bubble.
            valid_q <= 1'b1;
            addr_q  <= alu_result_in;
            rt_q    <= r_target_in;
            m2r_q   <= M2R_in;
            rw_q    <= 1'b0;
            data_q  <= '0;
            mis_q   <= 1'b1;
         end else begin
            valid_q <= valid_in;
            addr_q  <= alu_result_in;
            rt_q    <= r_target_in;
            m2r_q   <= M2R_in;
            rw_q    <= Reg_Write_in;
            data_q  <= '0;
         end
      end
   end

   assign valid_out     = valid_q;
   assign address_out   = addr_q;
   assign data_out      = data_q;
   assign r_target_out  = rt_q;
   assign Reg_Write_out = rw_q;
   assign M2R_out       = m2r_q;
   assign misalign_err  = mis_q;
   assign bus_err       = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores, misalignment, timeout, reset.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] alu_result_in, store_data_in;
   logic [4:0]  r_target_in;
   logic        Reg_Write_in, M2R_in, mem_read_in, mem_write_in;
   logic [1:0]  size_in;
   logic        load_unsigned_in;
   logic        stall, dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        valid_out;
   logic [31:0] address_out, data_out;
   logic [4:0]  r_target_out;
   logic        Reg_Write_out, M2R_out, misalign_err, bus_err;

   int vectors = 0;
   int miscompares = 0;

   mem_stage #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
      .store_data_in(store_data_in), .r_target_in(r_target_in), .Reg_Write_in(Reg_Write_in),
      .M2R_in(M2R_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .size_in(size_in), .load_unsigned_in(load_unsigned_in), .stall(stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .valid_out(valid_out),
      .address_out(address_out), .data_out(data_out), .r_target_out(r_target_out),
      .Reg_Write_out(Reg_Write_out), .M2R_out(M2R_out), .misalign_err(misalign_err),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rt, input logic rw, input logic m2r,
                        input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns);
      valid_in         = v;
      alu_result_in    = a;
      store_data_in    = sd;
      r_target_in      = rt;
      Reg_Write_in     = rw;
      M2R_in           = m2r;
      mem_read_in      = rd;
      mem_write_in     = wr;
      size_in          = sz;
      load_unsigned_in = uns;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b0;
      dm_ack = 1'b0;
      dm_rdata = 32'h0;
      drive(1'b1, 32'h100, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
      tick; tick;
      chk1("rst_dm_req", dm_req, 1'b0);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_valid_out", valid_out, 1'b0);
      chk("rst_address_out", address_out, 32'h0);
      chk("rst_dm_be", 32'(dm_be), 32'h0);

      // ALU op passes straight through
      rst = 1'b1;
      drive(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
      #1;
      chk1("alu_stall", stall, 1'b0);
      chk1("alu_dm_req", dm_req, 1'b0);
      tick;
      chk1("alu_valid_out", valid_out, 1'b1);
      chk("alu_address_out", address_out, 32'h1234);
      chk("alu_data_out", data_out, 32'h0);
      chk("alu_r_target_out", 32'(r_target_out), 32'd5);
      chk1("alu_reg_write_out", Reg_Write_out, 1'b1);

      // lb at 0x103, ack after 3 stalled cycles
      drive(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
      #1;
      chk1("lb_dm_req", dm_req, 1'b1);
      chk("lb_dm_be", 32'(dm_be), 32'h8);
      chk("lb_dm_addr", dm_addr, 32'h100);
      chk1("lb_dm_we", dm_we, 1'b0);
      chk1("lb_stall_c1", stall, 1'b1);
      tick;
      chk1("lb_stall_c2", stall, 1'b1);
      chk1("lb_bubble", valid_out, 1'b0);
      tick;
      chk1("lb_stall_c3", stall, 1'b1);
      tick;
      dm_ack = 1'b1;
      dm_rdata = 32'h80FF_FF00;
      #1;
      chk1("lb_ack_stall", stall, 1'b0);
      chk("lb_ack_dm_be", 32'(dm_be), 32'h8);
      tick;
      dm_ack = 1'b0;
      chk1("lb_valid_out", valid_out, 1'b1);
      chk("lb_data_out", data_out, 32'hFFFF_FF80);
      chk("lb_address_out", address_out, 32'h103);
      chk("lb_r_target_out", 32'(r_target_out), 32'd7);
      chk1("lb_m2r_out", M2R_out, 1'b1);

      // lbu with same-cycle ack
      drive(1'b1, 32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
      dm_ack = 1'b1;
      #1;
      chk1("lbu_stall", stall, 1'b0);
      tick;
      dm_ack = 1'b0;
      chk("lbu_data_out", data_out, 32'h0000_0080);
      chk1("lbu_valid_out", valid_out, 1'b1);

      // lh upper half, sign-extended
      drive(1'b1, 32'h202, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
      dm_ack = 1'b1;
      dm_rdata = 32'h8001_1234;
      #1;
      chk("lh_dm_be", 32'(dm_be), 32'hC);
      tick;
      dm_ack = 1'b0;
      chk("lh_data_out", data_out, 32'hFFFF_8001);

      // sh at 0x202 with one wait cycle
      drive(1'b1, 32'h202, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
      #1;
      chk1("sh_dm_we", dm_we, 1'b1);
      chk("sh_dm_be", 32'(dm_be), 32'hC);
      chk("sh_dm_wdata", dm_wdata, 32'hABCD_ABCD);
      chk1("sh_stall", stall, 1'b1);
      tick;
      dm_ack = 1'b1;
      dm_rdata = 32'hFFFF_FFFF;
      #1;
      chk1("sh_ack_stall", stall, 1'b0);
      chk("sh_wait_dm_wdata", dm_wdata, 32'hABCD_ABCD);
      tick;
      dm_ack = 1'b0;
      chk1("sh_valid_out", valid_out, 1'b1);
      chk("sh_data_out", data_out, 32'h0);

      // sb at 0x1
      drive(1'b1, 32'h1, 32'h0000_005A, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
      dm_ack = 1'b1;
      #1;
      chk("sb_dm_wdata", dm_wdata, 32'h5A5A_5A5A);
      chk("sb_dm_be", 32'(dm_be), 32'h2);
      tick;
      dm_ack = 1'b0;

      // misaligned lw at 0x102
      drive(1'b1, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      chk1("mis_dm_req", dm_req, 1'b0);
      chk1("mis_stall", stall, 1'b0);
      chk("mis_dm_be", 32'(dm_be), 32'h0);
      tick;
      chk1("mis_valid_out", valid_out, 1'b1);
      chk1("mis_reg_write_out", Reg_Write_out, 1'b0);
      chk1("mis_err_pulse", misalign_err, 1'b1);
      drive(1'b1, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
      tick;
      chk1("mis_err_clear", misalign_err, 1'b0);

      // lw that never gets an ack
      drive(1'b1, 32'h300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      #1;
      n = 0;
      while (stall === 1'b1 && n < 40) begin
         n++;
         tick;
      end
      chk("timeout_stall_cycles", 32'(n), 32'd15);
      tick;
      chk1("timeout_valid_out", valid_out, 1'b1);
      chk1("timeout_bus_err", bus_err, 1'b1);
      chk1("timeout_reg_write_out", Reg_Write_out, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
      tick;
      chk1("timeout_bus_err_clear", bus_err, 1'b0);

      // ack arrives in the timeout cycle
      drive(1'b1, 32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      dm_rdata = 32'hDEAD_BEEF;
      repeat (15) tick;
      dm_ack = 1'b1;
      #1;
      chk1("race_stall", stall, 1'b0);
      tick;
      dm_ack = 1'b0;
      chk1("race_valid_out", valid_out, 1'b1);
      chk1("race_reg_write_out", Reg_Write_out, 1'b1);
      chk("race_data_out", data_out, 32'hDEAD_BEEF);
      chk1("race_bus_err", bus_err, 1'b0);

      // reset during WAIT, late ack afterwards
      drive(1'b1, 32'h400, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      tick; tick;
      chk1("wait_stall", stall, 1'b1);
      rst = 1'b0;
      #1;
      chk1("arst_dm_req", dm_req, 1'b0);
      chk1("arst_stall", stall, 1'b0);
      chk("arst_address_out", address_out, 32'h0);
      chk1("arst_reg_write_out", Reg_Write_out, 1'b0);
      tick;
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0);
      dm_ack = 1'b1;
      #1;
      chk1("late_ack_dm_req", dm_req, 1'b0);
      tick;
      dm_ack = 1'b0;
      chk1("late_ack_valid_out", valid_out, 1'b0);
      chk("late_ack_data_out", data_out, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
